fetch_sequencer: RTL and testbench

- Owns the program counter for the IF stage and sequences instruction fetch.
- Chooses each cycle between four next-PC sources: EX branch redirect, ID jump, hazard stall, and sequential +4.
- Generates one-cycle flush pulses for the IF/ID and ID/EX pipeline registers, and detects end of program.
- Sits between the hazard unit, ID, EX and the instruction memory. Instruction memory consumes `pc`/`pc_valid` and no longer computes next PC itself.

---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/next_pc_mux.sv | 47 ++++
 rtl/fetch_sequencer.sv | 152 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Also holds the saturating-increment helper used when FETCH_SEQ_PERF_EN is defined.
package pipeline_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        SRC_BRANCH = 2'd0,
        SRC_JUMP   = 2'd1,
        SRC_STALL  = 2'd2,
        SRC_SEQ    = 2'd3
    } pc_src_e;

    localparam int          PC_STEP          = 4;
    localparam int          JUMP_ADDR_W      = 26;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;
    localparam logic [31:0] DEFAULT_HALT_PC  = 32'd100;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        return (en && (value != '1)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC priority select: branch > jump > stall > sequential.
// Redirect targets are forced word-aligned; misaligned_o flags the dropped low bits.
module next_pc_mux
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]      pc_i,
    input  logic                   stall_flag_i,
    input  logic                   jump_in_i,
    input  logic [JUMP_ADDR_W-1:0] jump_address_i,
    input  logic                   branch_taken_i,
    input  logic [ADDR_W-1:0]      branch_target_i,
    output logic [ADDR_W-1:0]      next_pc_o,
    output logic [1:0]             src_o,
    output logic                   misaligned_o
);

    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_aligned;
    pc_src_e           src;

    // Jump field is a byte address zero-extended into the PC width.
    assign jump_target    = ADDR_W'({jump_address_i[JUMP_ADDR_W-1:2], 2'b00});
    assign branch_aligned = {branch_target_i[ADDR_W-1:2], 2'b00};

    always_comb begin
        next_pc_o    = pc_i + ADDR_W'(PC_STEP);
        src          = SRC_SEQ;
        misaligned_o = 1'b0;
        if (branch_taken_i) begin
            next_pc_o    = branch_aligned;
            src          = SRC_BRANCH;
            misaligned_o = |branch_target_i[1:0];
        end else if (jump_in_i) begin
            next_pc_o    = jump_target;
            src          = SRC_JUMP;
            misaligned_o = |jump_address_i[1:0];
        end else if (stall_flag_i) begin
            next_pc_o = pc_i;
            src       = SRC_STALL;
        end
    end

    assign src_o = src;

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage program counter owner: boot, redirect, stall, flush pulses and halt detection.
// Optional perf counters are built only when FETCH_SEQ_PERF_EN is defined.
//
// state | meaning
// BOOT  | one cycle after reset release, pc=RESET_PC, no fetch yet
// RUN   | fetching; next pc chosen by next_pc_mux
// STALL | pc held by load-use stall; same next-pc rules as RUN
// HALT  | end of program reached; frozen until reset
module fetch_sequencer
    import pipeline_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter logic [ADDR_W-1:0] HALT_PC  = ADDR_W'(DEFAULT_HALT_PC)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall_flag,
    input  logic                   jump_in,
    input  logic [JUMP_ADDR_W-1:0] jump_address,
    input  logic                   branch_taken,
    input  logic [ADDR_W-1:0]      branch_target,
    output logic [ADDR_W-1:0]      pc,
    output logic                   pc_valid,
    output logic                   flush_ifid,
    output logic                   flush_idex,
    output logic                   misaligned,
    output logic                   halted
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0]            stall_cycles,
    output logic [31:0]            redirect_count,
    output logic [31:0]            fetch_count
`endif
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pc_valid_q, pc_valid_d;
    logic              flush_ifid_q, flush_ifid_d;
    logic              flush_idex_q, flush_idex_d;
    logic              misaligned_q, misaligned_d;
    logic              halted_q, halted_d;

    logic [ADDR_W-1:0] mux_next_pc;
    logic [1:0]        mux_src_raw;
    pc_src_e           mux_src;
    logic              mux_misaligned;
    logic              is_redirect;

    next_pc_mux #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_mux (
        .pc_i            (pc_q),
        .stall_flag_i    (stall_flag),
        .jump_in_i       (jump_in),
        .jump_address_i  (jump_address),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .next_pc_o       (mux_next_pc),
        .src_o           (mux_src_raw),
        .misaligned_o    (mux_misaligned)
    );

    assign mux_src     = pc_src_e'(mux_src_raw);
    assign is_redirect = (mux_src == SRC_BRANCH) || (mux_src == SRC_JUMP);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_valid_d   = pc_valid_q;
        flush_ifid_d = 1'b0;
        flush_idex_d = 1'b0;
        misaligned_d = 1'b0;
        halted_d     = halted_q;
        case (state_q)
            BOOT: begin
                state_d    = RUN;
                pc_valid_d = 1'b1;
            end
            RUN, STALL: begin
                pc_d         = mux_next_pc;
                pc_valid_d   = 1'b1;
                flush_ifid_d = is_redirect;
                flush_idex_d = (mux_src == SRC_BRANCH);
                misaligned_d = mux_misaligned;
                state_d      = (mux_src == SRC_STALL) ? STALL : RUN;
                // Halt wins over the state choice, but the redirect's pulses still go out.
                if (mux_next_pc == HALT_PC) begin
                    pc_valid_d = 1'b0;
                    halted_d   = 1'b1;
                    state_d    = HALT;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            pc_valid_q   <= 1'b0;
            flush_ifid_q <= 1'b0;
            flush_idex_q <= 1'b0;
            misaligned_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_valid_q   <= pc_valid_d;
            flush_ifid_q <= flush_ifid_d;
            flush_idex_q <= flush_idex_d;
            misaligned_q <= misaligned_d;
            halted_q     <= halted_d;
        end
    end

    assign pc         = pc_q;
    assign pc_valid   = pc_valid_q;
    assign flush_ifid = flush_ifid_q;
    assign flush_idex = flush_idex_q;
    assign misaligned = misaligned_q;
    assign halted     = halted_q;

`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] redirect_count_q;
    logic [31:0] fetch_count_q;
    logic        active;

    assign active = (state_q == RUN) || (state_q == STALL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q   <= 32'd0;
            redirect_count_q <= 32'd0;
            fetch_count_q    <= 32'd0;
        end else if (state_q != HALT) begin
            stall_cycles_q   <= sat_inc(stall_cycles_q, state_q == STALL);
            redirect_count_q <= sat_inc(redirect_count_q, active && is_redirect);
            fetch_count_q    <= sat_inc(fetch_count_q, pc_valid_q);
        end
    end

    assign stall_cycles   = stall_cycles_q;
    assign redirect_count = redirect_count_q;
    assign fetch_count    = fetch_count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: stimulus pushes expected outputs,
// each step pops them after the clock edge and compares.
module tb_fetch_sequencer;

    typedef struct packed {
        logic [31:0] pc;
        logic        v;
        logic        fi;
        logic        fe;
        logic        mis;
        logic        h;
    } obs_t;

    typedef struct packed {
        logic        st;
        logic        jmp;
        logic [25:0] ja;
        logic        br;
        logic [31:0] bt;
    } stim_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_flag = 1'b0;
    logic        jump_in = 1'b0;
    logic [25:0] jump_address = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] pc;
    logic        pc_valid, flush_ifid, flush_idex, misaligned, halted;

    obs_t  obs;
    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall_flag    (stall_flag),
        .jump_in       (jump_in),
        .jump_address  (jump_address),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .flush_ifid    (flush_ifid),
        .flush_idex    (flush_idex),
        .misaligned    (misaligned),
        .halted        (halted)
    );

    assign obs = {pc, pc_valid, flush_ifid, flush_idex, misaligned, halted};

    function automatic stim_t S(input logic st, input logic jmp, input logic [25:0] ja,
                                input logic br, input logic [31:0] bt);
        return {st, jmp, ja, br, bt};
    endfunction

    function automatic obs_t E(input logic [31:0] p, input logic v, input logic fi,
                               input logic fe, input logic mis, input logic h);
        return {p, v, fi, fe, mis, h};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("pc=%h valid=%b fifid=%b fidex=%b mis=%b halt=%b",
                         o.pc, o.v, o.fi, o.fe, o.mis, o.h);
    endfunction

    task automatic drive(input stim_t s, input obs_t e, input string nm);
        stall_flag    = s.st;
        jump_in       = s.jmp;
        jump_address  = s.ja;
        branch_taken  = s.br;
        branch_target = s.bt;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic test_reset();
        obs_t r;
        #12;
        r = E(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== r) begin
            failures++;
            $display("FAIL reset: got %s expected %s", fmt(obs), fmt(r));
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_sequential();
        stim_t s[3];
        obs_t  e[3];
        obs_t  x;
        string nm;
        s = '{S(0,0,0,0,0), S(0,0,0,0,0), S(0,0,0,0,0)};
        e = '{E(32'h0,1,0,0,0,0), E(32'h4,1,0,0,0,0), E(32'h8,1,0,0,0,0)};
        for (int i = 0; i < 3; i++) begin
            drive(s[i], e[i], "sequential");
            @(posedge clk); #1;
            x = exp_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (obs !== x) begin
                failures++;
                $display("FAIL %s[%0d]: got %s expected %s", nm, i, fmt(obs), fmt(x));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        stim_t s[4];
        obs_t  e[4];
        obs_t  x;
        string nm;
        s = '{S(1,0,0,0,0), S(1,0,0,0,0), S(0,0,0,0,0), S(0,0,0,0,0)};
        e = '{E(32'h8,1,0,0,0,0), E(32'h8,1,0,0,0,0), E(32'hC,1,0,0,0,0), E(32'h10,1,0,0,0,0)};
        for (int i = 0; i < 4; i++) begin
            drive(s[i], e[i], "stall");
            @(posedge clk); #1;
            x = exp_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (obs !== x) begin
                failures++;
                $display("FAIL %s[%0d]: got %s expected %s", nm, i, fmt(obs), fmt(x));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch_over_stall();
        stim_t s[2];
        obs_t  e[2];
        obs_t  x;
        string nm;
        s = '{S(1,0,0,1,32'h40), S(0,0,0,0,0)};
        e = '{E(32'h40,1,1,1,0,0), E(32'h44,1,0,0,0,0)};
        for (int i = 0; i < 2; i++) begin
            drive(s[i], e[i], "branch_over_stall");
            @(posedge clk); #1;
            x = exp_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (obs !== x) begin
                failures++;
                $display("FAIL %s[%0d]: got %s expected %s", nm, i, fmt(obs), fmt(x));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_priority_jump();
        stim_t s[4];
        obs_t  e[4];
        obs_t  x;
        string nm;
        s = '{S(0,1,26'h20,1,32'h30), S(0,1,26'h22,0,0), S(1,1,26'h22,0,0), S(0,0,0,0,0)};
        e = '{E(32'h30,1,1,1,0,0), E(32'h20,1,1,0,1,0), E(32'h20,1,1,0,1,0), E(32'h24,1,0,0,0,0)};
        for (int i = 0; i < 4; i++) begin
            drive(s[i], e[i], "priority_jump");
            @(posedge clk); #1;
            x = exp_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (obs !== x) begin
                failures++;
                $display("FAIL %s[%0d]: got %s expected %s", nm, i, fmt(obs), fmt(x));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[4];
        obs_t  e[4];
        obs_t  x;
        string nm;
        s = '{S(0,0,0,1,32'h41), S(0,0,0,1,32'h50), S(0,1,26'h3FFFFFC,0,0), S(0,0,0,0,0)};
        e = '{E(32'h40,1,1,1,1,0), E(32'h50,1,1,1,0,0), E(32'h03FFFFFC,1,1,0,0,0),
              E(32'h04000000,1,0,0,0,0)};
        for (int i = 0; i < 4; i++) begin
            drive(s[i], e[i], "back_to_back");
            @(posedge clk); #1;
            x = exp_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (obs !== x) begin
                failures++;
                $display("FAIL %s[%0d]: got %s expected %s", nm, i, fmt(obs), fmt(x));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        stim_t s[4];
        obs_t  e[4];
        obs_t  x;
        string nm;
        s = '{S(0,0,0,1,32'hFFFFFFF8), S(0,0,0,0,0), S(0,0,0,0,0), S(0,0,0,0,0)};
        e = '{E(32'hFFFFFFF8,1,1,1,0,0), E(32'hFFFFFFFC,1,0,0,0,0), E(32'h0,1,0,0,0,0),
              E(32'h4,1,0,0,0,0)};
        for (int i = 0; i < 4; i++) begin
            drive(s[i], e[i], "wrap");
            @(posedge clk); #1;
            x = exp_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (obs !== x) begin
                failures++;
                $display("FAIL %s[%0d]: got %s expected %s", nm, i, fmt(obs), fmt(x));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_halt_seq();
        stim_t s[7];
        obs_t  e[7];
        obs_t  x;
        string nm;
        s = '{S(0,1,26'h58,0,0), S(0,0,0,0,0), S(0,0,0,0,0), S(0,0,0,0,0),
              S(1,1,26'h300,1,32'h200), S(0,1,26'h8,0,0), S(0,0,0,1,32'h10)};
        e = '{E(32'h58,1,1,0,0,0), E(32'h5C,1,0,0,0,0), E(32'h60,1,0,0,0,0),
              E(32'h64,0,0,0,0,1), E(32'h64,0,0,0,0,1), E(32'h64,0,0,0,0,1),
              E(32'h64,0,0,0,0,1)};
        for (int i = 0; i < 7; i++) begin
            drive(s[i], e[i], "halt_seq");
            @(posedge clk); #1;
            x = exp_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (obs !== x) begin
                failures++;
                $display("FAIL %s[%0d]: got %s expected %s", nm, i, fmt(obs), fmt(x));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midcycle();
        stim_t s[4];
        obs_t  e[4];
        obs_t  x;
        obs_t  r;
        string nm;
        #2;
        reset = 1'b0;
        #1;
        r = E(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== r) begin
            failures++;
            $display("FAIL reset_midcycle: got %s expected %s", fmt(obs), fmt(r));
        end
        @(negedge clk);
        reset = 1'b1;
        // First step lands on the BOOT edge with stall high; the last one halts via branch.
        s = '{S(1,0,0,0,0), S(1,0,0,0,0), S(0,0,0,0,0), S(0,0,0,1,32'h66)};
        e = '{E(32'h0,1,0,0,0,0), E(32'h0,1,0,0,0,0), E(32'h4,1,0,0,0,0), E(32'h64,0,1,1,1,1)};
        for (int i = 0; i < 4; i++) begin
            drive(s[i], e[i], "boot_and_branch_halt");
            @(posedge clk); #1;
            x = exp_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (obs !== x) begin
                failures++;
                $display("FAIL %s[%0d]: got %s expected %s", nm, i, fmt(obs), fmt(x));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_aborts_pulse();
        obs_t x;
        obs_t r;
        string nm;
        #2;
        reset = 1'b0;
        #1;
        r = E(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== r) begin
            failures++;
            $display("FAIL reset_aborts_pulse: got %s expected %s", fmt(obs), fmt(r));
        end
        @(negedge clk);
        reset = 1'b1;
        drive(S(0,0,0,0,0), E(32'h0,1,0,0,0,0), "after_abort");
        @(posedge clk); #1;
        x = exp_q.pop_front(); nm = name_q.pop_front();
        checks++;
        if (obs !== x) begin
            failures++;
            $display("FAIL %s: got %s expected %s", nm, fmt(obs), fmt(x));
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_over_stall();
        test_priority_jump();
        test_back_to_back();
        test_wrap();
        test_halt_seq();
        test_reset_midcycle();
        test_reset_aborts_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
